// File: rtl/pwm_carrier_event_gen.sv
// -----------------------------------------------------------------------------
// pwm_carrier_event_gen
//
// Triangle (up/down) PWM carrier generator and peak/valley event source for
// the timing manager. The carrier ramps 0 -> max_active -> 0 and steps once per
// prescaler tick. Single-cycle peak and valley pulses are emitted. A selectable
// event_qualifier pulse drives the timing manager's user_ratio counter and its
// manual-trigger gate.
//
// Parameters
//   CNT_W            carrier counter / carrier_max width
//   DIV_W            prescaler width
//
// Ports
//   clk              in   1      system clock
//   rst_n            in   1      synchronous, active-low reset
//   enable           in   1      1 = run carrier, 0 = return to IDLE
//   carrier_max      in   CNT_W  requested peak value. Shadowed into max_active
//                                only on IDLE->UP and at each valley.
//   carrier_div      in   DIV_W  carrier steps once every carrier_div+1 clocks
//   event_sel        in   2      bit0 = qualify valleys, bit1 = qualify peaks
//   sync_in          in   1      external restart (CARRIER_SYNC_EN builds only)
//   carrier          out  CNT_W  current carrier count
//   carrier_dir      out  1      1 = counting up, 0 = counting down
//   peak_pulse       out  1      1-cycle pulse when carrier reaches max_active
//   valley_pulse     out  1      1-cycle pulse when carrier returns to 0
//   event_qualifier  out  1      (sel[0] & valley) | (sel[1] & peak)
//   cfg_err          out  1      sticky: a sampled carrier_max < 2 was clamped
//
// Configuration macro
//   CARRIER_SYNC_EN  When defined, this adds the sync_in port. A rising edge on
//                    sync_in restarts the carrier at a valley. When the macro
//                    is undefined, the carrier is free-running only.
// -----------------------------------------------------------------------------
module pwm_carrier_event_gen #(
  parameter int CNT_W = 16,
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef CARRIER_SYNC_EN
  input  logic             sync_in,
`endif
  input  logic             enable,
  input  logic [CNT_W-1:0] carrier_max,
  input  logic [DIV_W-1:0] carrier_div,
  input  logic [1:0]       event_sel,
  output logic [CNT_W-1:0] carrier,
  output logic             carrier_dir,
  output logic             peak_pulse,
  output logic             valley_pulse,
  output logic             event_qualifier,
  output logic             cfg_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] MIN_MAX = CNT_W'(2);

  state_t           state;
  logic [DIV_W-1:0] prescaler;
  logic [CNT_W-1:0] max_active;

  // ---------------------------------------------------------------------------
  // Shadow-load value. Peaks below 2 would collapse the triangle and make peak
  // and valley coincide. Such values are clamped and flagged through cfg_err.
  // ---------------------------------------------------------------------------
  logic             max_clamp;
  logic [CNT_W-1:0] max_load;

  always_comb begin
    max_clamp = (carrier_max < MIN_MAX);
    max_load  = max_clamp ? MIN_MAX : carrier_max;
  end

  // ---------------------------------------------------------------------------
  // Prescaler. tick marks the clock on which the carrier moves. The ">=" in
  // the wrap test covers carrier_div being lowered below the current count:
  // the prescaler wraps on the next cycle without producing a tick.
  // ---------------------------------------------------------------------------
  logic             tick;
  logic             pre_wrap;
  logic [DIV_W-1:0] pre_inc;

  always_comb begin
    tick     = (prescaler == carrier_div);
    pre_wrap = (prescaler >= carrier_div);
    pre_inc  = prescaler + DIV_W'(1);
  end

  // Neighbouring carrier values and their turn-around conditions.
  logic [CNT_W-1:0] carrier_inc;
  logic [CNT_W-1:0] carrier_dec;
  logic             hit_peak;
  logic             hit_valley;

  always_comb begin
    carrier_inc = carrier + CNT_W'(1);
    carrier_dec = carrier - CNT_W'(1);
    hit_peak    = (carrier_inc == max_active);
    hit_valley  = (carrier_dec == '0);
  end

  // ---------------------------------------------------------------------------
  // Optional external synchronisation: registered rising-edge detect.
  // ---------------------------------------------------------------------------
  logic sync_edge;

`ifdef CARRIER_SYNC_EN
  logic sync_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= 1'b0;
    end else begin
      sync_q <= sync_in;
    end
  end

  always_comb begin
    sync_edge = sync_in & ~sync_q;
  end
`else
  always_comb begin
    sync_edge = 1'b0;
  end
`endif

  // ---------------------------------------------------------------------------
  // Carrier FSM. All outputs are registered here. The pulses default low each
  // cycle, so no pulse can ever stretch to two cycles. event_qualifier is
  // computed from the same-cycle pulse decisions, so it lands together with
  // them.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= IDLE;
      carrier         <= '0;
      carrier_dir     <= 1'b1;
      peak_pulse      <= 1'b0;
      valley_pulse    <= 1'b0;
      event_qualifier <= 1'b0;
      cfg_err         <= 1'b0;
      prescaler       <= '0;
      max_active      <= MIN_MAX;
    end else begin
      peak_pulse      <= 1'b0;
      valley_pulse    <= 1'b0;
      event_qualifier <= 1'b0;

      case (state)
        IDLE: begin
          carrier     <= '0;
          carrier_dir <= 1'b1;
          prescaler   <= '0;
          cfg_err     <= 1'b0;
          if (enable) begin
            // Entry is not a valley, so no pulse here. The first event is the
            // first peak.
            state      <= UP;
            max_active <= max_load;
            cfg_err    <= max_clamp;
          end
        end

        UP, DOWN: begin
          if (!enable) begin
            // Drop straight to the IDLE values so the carrier reads 0 on the
            // cycle after enable is seen low.
            state       <= IDLE;
            carrier     <= '0;
            carrier_dir <= 1'b1;
            prescaler   <= '0;
            cfg_err     <= 1'b0;
          end else if (sync_edge) begin
            // External restart behaves like a valley.
            state           <= UP;
            carrier         <= '0;
            carrier_dir     <= 1'b1;
            prescaler       <= '0;
            max_active      <= max_load;
            cfg_err         <= cfg_err | max_clamp;
            valley_pulse    <= 1'b1;
            event_qualifier <= event_sel[0];
          end else begin
            prescaler <= pre_wrap ? '0 : pre_inc;
            if (tick) begin
              if (state == UP) begin
                carrier <= carrier_inc;
                if (hit_peak) begin
                  state           <= DOWN;
                  carrier_dir     <= 1'b0;
                  peak_pulse      <= 1'b1;
                  event_qualifier <= event_sel[1];
                end
              end else begin
                carrier <= carrier_dec;
                if (hit_valley) begin
                  // The valley is the only point where the shadowed peak may
                  // change, so every period is symmetric.
                  state           <= UP;
                  carrier_dir     <= 1'b1;
                  valley_pulse    <= 1'b1;
                  event_qualifier <= event_sel[0];
                  max_active      <= max_load;
                  cfg_err         <= cfg_err | max_clamp;
                end
              end
            end
          end
        end

        default: begin
          state       <= IDLE;
          carrier     <= '0;
          carrier_dir <= 1'b1;
          prescaler   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_carrier_event_gen.sv
// -----------------------------------------------------------------------------
// tb_pwm_carrier_event_gen
//
// Table-driven bench for pwm_carrier_event_gen. Each record holds the inputs
// for one clock edge together with the outputs expected after that edge.
// Expected triangle values come from a closed-form model:
//   s = k / (div+1)
//   p = s mod 2M
//   carrier = (p <= M) ? p : 2M - p
// Records are driven on the falling edge and their expectations queued. They
// are popped and compared on the next falling edge.
// -----------------------------------------------------------------------------
module tb_pwm_carrier_event_gen;

  localparam int CNT_W = 16;
  localparam int DIV_W = 8;

  logic             clk;
  logic             rst_n;
  logic             enable;
  logic             sync_in;
  logic [CNT_W-1:0] carrier_max;
  logic [DIV_W-1:0] carrier_div;
  logic [1:0]       event_sel;
  logic [CNT_W-1:0] carrier;
  logic             carrier_dir;
  logic             peak_pulse;
  logic             valley_pulse;
  logic             event_qualifier;
  logic             cfg_err;

  pwm_carrier_event_gen #(.CNT_W(CNT_W), .DIV_W(DIV_W)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
`ifdef CARRIER_SYNC_EN
    .sync_in         (sync_in),
`endif
    .enable          (enable),
    .carrier_max     (carrier_max),
    .carrier_div     (carrier_div),
    .event_sel       (event_sel),
    .carrier         (carrier),
    .carrier_dir     (carrier_dir),
    .peak_pulse      (peak_pulse),
    .valley_pulse    (valley_pulse),
    .event_qualifier (event_qualifier),
    .cfg_err         (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic             rst_n;
    logic             en;
    logic             sync;
    logic [CNT_W-1:0] cmax;
    logic [DIV_W-1:0] div;
    logic [1:0]       sel;
    logic [CNT_W-1:0] e_car;
    logic             e_dir;
    logic             e_peak;
    logic             e_valley;
    logic             e_qual;
    logic             e_cfg;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  logic cur_sync;
  int   errors;
  int   checks;
  int   vec_idx;

  function automatic void add_vec(input logic rst, input logic en, input int cmax,
                                  input int div, input logic [1:0] sel, input int car,
                                  input logic dir, input logic pk, input logic vl,
                                  input logic q, input logic cfg);
    vec_t v;
    v.rst_n    = rst;
    v.en       = en;
    v.sync     = cur_sync;
    v.cmax     = CNT_W'(cmax);
    v.div      = DIV_W'(div);
    v.sel      = sel;
    v.e_car    = CNT_W'(car);
    v.e_dir    = dir;
    v.e_peak   = pk;
    v.e_valley = vl;
    v.e_qual   = q;
    v.e_cfg    = cfg;
    vecs.push_back(v);
  endfunction

  // Edges k_lo..k_hi of a running carrier. k = 0 is the IDLE->UP edge.
  function automatic void add_run(input int cmax, input int div, input logic [1:0] sel,
                                  input int m, input int k_lo, input int k_hi,
                                  input logic cfg);
    for (int k = k_lo; k <= k_hi; k++) begin
      int   s;
      int   p;
      int   car;
      logic on_tick;
      logic pk;
      logic vl;
      s       = k / (div + 1);
      on_tick = ((k % (div + 1)) == 0);
      p       = s % (2 * m);
      car     = (p <= m) ? p : (2 * m - p);
      pk      = on_tick && (p == m);
      vl      = on_tick && (p == 0) && (s > 0);
      add_vec(1'b1, 1'b1, cmax, div, sel, car, (p < m), pk, vl,
              (sel[0] & vl) | (sel[1] & pk), cfg);
    end
  endfunction

  function automatic void add_idle();
    add_vec(1'b1, 1'b0, 4, 0, 2'b01, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction

  task automatic check_one();
    vec_t e;
    logic [CNT_W+4:0] act;
    logic [CNT_W+4:0] exp_v;
    e     = sb.pop_front();
    act   = {carrier, carrier_dir, peak_pulse, valley_pulse, event_qualifier, cfg_err};
    exp_v = {e.e_car, e.e_dir, e.e_peak, e.e_valley, e.e_qual, e.e_cfg};
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL vec%0d: got car=%0d dir=%b pk=%b vl=%b q=%b cfg=%b, want car=%0d dir=%b pk=%b vl=%b q=%b cfg=%b",
               vec_idx, carrier, carrier_dir, peak_pulse, valley_pulse, event_qualifier, cfg_err,
               e.e_car, e.e_dir, e.e_peak, e.e_valley, e.e_qual, e.e_cfg);
    end else begin
      $display("ok   vec%0d: car=%0d dir=%b pk=%b vl=%b q=%b cfg=%b",
               vec_idx, carrier, carrier_dir, peak_pulse, valley_pulse, event_qualifier, cfg_err);
    end
    vec_idx++;
  endtask

  initial begin
    errors      = 0;
    checks      = 0;
    vec_idx     = 0;
    cur_sync    = 1'b0;
    rst_n       = 1'b0;
    enable      = 1'b0;
    sync_in     = 1'b0;
    carrier_max = '0;
    carrier_div = '0;
    event_sel   = '0;

    // Reset state.
    add_vec(1'b0, 1'b0, 4, 0, 2'b01, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    add_vec(1'b0, 1'b1, 4, 0, 2'b01, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    // 1: max=4, div=0, valleys qualified.
    add_run(4, 0, 2'b01, 4, 0, 20, 1'b0);
    add_idle();
    // 2: max=4, div=1, peaks and valleys qualified.
    add_run(4, 1, 2'b11, 4, 0, 33, 1'b0);
    add_idle();
    // 3: max raised to 6 at carrier=2 rising. It takes effect after the valley.
    add_run(4, 0, 2'b11, 4, 0, 2, 1'b0);
    add_run(6, 0, 2'b11, 4, 3, 8, 1'b0);
    add_run(6, 0, 2'b11, 6, 1, 13, 1'b0);
    add_idle();
    // 4: clamp to 2, sticky flag, cleared by reset and by enable low.
    add_run(1, 0, 2'b01, 2, 0, 10, 1'b1);
    add_vec(1'b0, 1'b1, 1, 0, 2'b01, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    add_run(1, 0, 2'b01, 2, 0, 6, 1'b1);
    add_idle();
    add_run(4, 0, 2'b01, 4, 0, 3, 1'b0);
    // 5: enable dropped at carrier=3 on the way down (restart first).
    add_idle();
    add_run(4, 0, 2'b01, 4, 0, 5, 1'b0);
    add_idle();
    // No qualification selected, then peaks only.
    add_run(3, 2, 2'b00, 3, 0, 25, 1'b0);
    add_idle();
    add_run(5, 0, 2'b10, 5, 0, 22, 1'b0);
`ifdef CARRIER_SYNC_EN
    // 6: sync rise at carrier=3 rising forces an immediate valley restart.
    add_idle();
    add_run(4, 0, 2'b01, 4, 0, 3, 1'b0);
    cur_sync = 1'b1;
    add_vec(1'b1, 1'b1, 4, 0, 2'b01, 0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    add_run(4, 0, 2'b01, 4, 1, 9, 1'b0);
    cur_sync = 1'b0;
`endif
    add_idle();

    foreach (vecs[i]) begin
      @(negedge clk);
      if (sb.size() > 0) check_one();
      rst_n       = vecs[i].rst_n;
      enable      = vecs[i].en;
      sync_in     = vecs[i].sync;
      carrier_max = vecs[i].cmax;
      carrier_div = vecs[i].div;
      event_sel   = vecs[i].sel;
      sb.push_back(vecs[i]);
    end
    @(negedge clk);
    if (sb.size() > 0) check_one();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
